// File: rtl/regfile_access_arbiter_pkg.sv
// Shared encodings for the register-file access arbiter: op codes, FSM states
// and default widths.
package regfile_ctrl_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;

  // Op field is {RD,WR}: bit 1 requests the A/B read, bit 0 the write.
  localparam logic [1:0] RW_NOP  = 2'b00;
  localparam logic [1:0] RW_WR   = 2'b01;
  localparam logic [1:0] RW_RD   = 2'b10;
  localparam logic [1:0] RW_RDWR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

endpackage

// File: rtl/regfile_access_arbiter_rr.sv
// Two-way round-robin grant: on contention the requester that did not win last
// time gets the grant; a lone requester is always granted.
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/regfile_access_arbiter.sv
// Shares one register file between two requesters: accepts one command at a
// time, issues it as a single register-file access and returns the read data.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high. req_ready is only offered in IDLE; rsp_valid holds with stable data until
// the granted requester's rsp_ready is seen high.
module regfile_access_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                clk_main,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [3:0]          req_rw,
  input  logic [2*ADDR_W-1:0] req_da,
  input  logic [2*ADDR_W-1:0] req_aa,
  input  logic [2*ADDR_W-1:0] req_ba,
  input  logic [2*DATA_W-1:0] req_d,
  output logic [1:0]          rsp_valid,
  input  logic [1:0]          rsp_ready,
  output logic [DATA_W-1:0]   rsp_a,
  output logic [DATA_W-1:0]   rsp_b,
  output logic                rf_en,
  output logic [1:0]          rf_rw,
  output logic [ADDR_W-1:0]   rf_da,
  output logic [ADDR_W-1:0]   rf_aa,
  output logic [ADDR_W-1:0]   rf_ba,
  output logic [DATA_W-1:0]   rf_d,
  input  logic [DATA_W-1:0]   rf_a,
  input  logic [DATA_W-1:0]   rf_b,
  output logic [1:0]          dbg_state
);

  state_e              state_q, state_d;
  logic                rr_last_q, rr_last_d;
  logic                id_q, id_d;
  logic [1:0]          op_q, op_d;
  logic                rf_en_q, rf_en_d;
  logic [1:0]          rf_rw_q, rf_rw_d;
  logic [ADDR_W-1:0]   rf_da_q, rf_da_d, rf_aa_q, rf_aa_d, rf_ba_q, rf_ba_d;
  logic [DATA_W-1:0]   rf_d_q, rf_d_d;
  logic [1:0]          rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_a_q, rsp_a_d, rsp_b_q, rsp_b_d;
  logic [1:0]          gnt;
  logic                sel;

  rr_arbiter_2 u_arb (
    .req  (req_valid),
    .last (rr_last_q),
    .gnt  (gnt)
  );

  assign sel       = gnt[1];
  assign req_ready = (state_q == ST_IDLE) ? gnt : 2'b00;

  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    id_d        = id_q;
    op_d        = op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_a_d     = rsp_a_q;
    rsp_b_d     = rsp_b_q;
    // The register-file bus is driven for exactly one cycle: the cycle after accept.
    rf_en_d     = 1'b0;
    rf_rw_d     = RW_NOP;
    rf_da_d     = '0;
    rf_aa_d     = '0;
    rf_ba_d     = '0;
    rf_d_d      = '0;
    case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          id_d      = sel;
          op_d      = sel ? req_rw[3:2] : req_rw[1:0];
          rr_last_d = sel;
          rf_en_d   = (op_d != RW_NOP);
          rf_rw_d   = op_d;
          rf_da_d   = sel ? req_da[2*ADDR_W-1:ADDR_W] : req_da[ADDR_W-1:0];
          rf_aa_d   = sel ? req_aa[2*ADDR_W-1:ADDR_W] : req_aa[ADDR_W-1:0];
          rf_ba_d   = sel ? req_ba[2*ADDR_W-1:ADDR_W] : req_ba[ADDR_W-1:0];
          rf_d_d    = sel ? req_d[2*DATA_W-1:DATA_W] : req_d[DATA_W-1:0];
          rsp_a_d   = '0;
          rsp_b_d   = '0;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (op_q[1]) begin
          state_d = ST_CAPTURE;
        end else begin
          state_d     = ST_RESP;
          rsp_valid_d = id_q ? 2'b10 : 2'b01;
        end
      end
      ST_CAPTURE: begin
        rsp_a_d     = rf_a;
        rsp_b_d     = rf_b;
        rsp_valid_d = id_q ? 2'b10 : 2'b01;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready[id_q]) begin
          rsp_valid_d = 2'b00;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_main or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      rr_last_q   <= 1'b1;
      id_q        <= 1'b0;
      op_q        <= RW_NOP;
      rsp_valid_q <= 2'b00;
      rsp_a_q     <= '0;
      rsp_b_q     <= '0;
      rf_en_q     <= 1'b0;
      rf_rw_q     <= RW_NOP;
      rf_da_q     <= '0;
      rf_aa_q     <= '0;
      rf_ba_q     <= '0;
      rf_d_q      <= '0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      id_q        <= id_d;
      op_q        <= op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_a_q     <= rsp_a_d;
      rsp_b_q     <= rsp_b_d;
      rf_en_q     <= rf_en_d;
      rf_rw_q     <= rf_rw_d;
      rf_da_q     <= rf_da_d;
      rf_aa_q     <= rf_aa_d;
      rf_ba_q     <= rf_ba_d;
      rf_d_q      <= rf_d_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_a     = rsp_a_q;
  assign rsp_b     = rsp_b_q;
  assign rf_en     = rf_en_q;
  assign rf_rw     = rf_rw_q;
  assign rf_da     = rf_da_q;
  assign rf_aa     = rf_aa_q;
  assign rf_ba     = rf_ba_q;
  assign rf_d      = rf_d_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Bench for regfile_access_arbiter: a behavioural register file, a transaction
// model checked every cycle, directed scenarios and a randomized traffic phase.
module tb_regfile_access_arbiter;
  import regfile_ctrl_pkg::*;

  logic        clk_main = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [3:0]  req_rw;
  logic [7:0]  req_da, req_aa, req_ba;
  logic [31:0] req_d;
  logic [15:0] rsp_a, rsp_b, rf_d, rf_a, rf_b;
  logic        rf_en;
  logic [1:0]  rf_rw, dbg_state;
  logic [3:0]  rf_da, rf_aa, rf_ba;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  always #5 clk_main = ~clk_main;

  regfile_access_arbiter dut (
    .clk_main(clk_main), .reset(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_da(req_da), .req_aa(req_aa), .req_ba(req_ba), .req_d(req_d),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_a(rsp_a), .rsp_b(rsp_b),
    .rf_en(rf_en), .rf_rw(rf_rw), .rf_da(rf_da), .rf_aa(rf_aa), .rf_ba(rf_ba),
    .rf_d(rf_d), .rf_a(rf_a), .rf_b(rf_b), .dbg_state(dbg_state)
  );

  // Register file: read ports update on the enabled edge with pre-write contents.
  logic [15:0] mem [16];
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    rf_a = '0;
    rf_b = '0;
  end
  always @(posedge clk_main) begin
    if (rf_en) begin
      if (rf_rw[1]) begin
        rf_a <= mem[rf_aa];
        rf_b <= mem[rf_ba];
      end
      if (rf_rw[0]) mem[rf_da] <= rf_d;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  logic [31:0] exp_q[$];
  logic [15:0] regs [16];
  bit          busy;
  bit          last_id;
  bit          cid;
  logic [1:0]  cop;
  logic [3:0]  c_da, c_aa, c_ba;
  logic [15:0] c_d;
  int          cyc;

  initial for (int i = 0; i < 16; i++) regs[i] = '0;

  function automatic logic [1:0] pick(input logic [1:0] v, input bit last);
    if (v == 2'b11) return last ? 2'b01 : 2'b10;
    return v;
  endfunction

  always @(negedge clk_main) begin
    logic [1:0]  er, ev;
    logic [15:0] ea, eb;
    bit          was_busy, s;
    int          lat;
    if (!rst_n) begin
      busy    = 0;
      last_id = 1;
      exp_q.delete();
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_ab", {rsp_a, rsp_b}, 0);
      chk("rst_rf_bus", {rf_en, rf_rw, rf_da, rf_aa, rf_ba, rf_d}, 0);
      chk("rst_state", dbg_state, ST_IDLE);
    end else begin
      er = busy ? 2'b00 : pick(req_valid, last_id);
      chk("req_ready", req_ready, er);
      ev = 2'b00;
      if (busy) begin
        cyc++;
        lat = cop[1] ? 3 : 2;
        if (cyc >= lat) ev = cid ? 2'b10 : 2'b01;
      end
      chk("rsp_valid", rsp_valid, ev);
      if (busy && cyc == 1)
        chk("rf_bus_issue", {rf_en, rf_rw, rf_da, rf_aa, rf_ba, rf_d},
            {cop != 2'b00, cop, c_da, c_aa, c_ba, c_d});
      else
        chk("rf_bus_idle", {rf_en, rf_rw, rf_da, rf_aa, rf_ba, rf_d}, 0);
      if (ev != 2'b00 && exp_q.size() > 0) chk("rsp_data", {rsp_a, rsp_b}, exp_q[0]);
      was_busy = busy;
      if (busy && ev != 2'b00 && rsp_ready[cid]) begin
        busy = 0;
        void'(exp_q.pop_front());
      end
      if (!was_busy && er != 2'b00) begin
        s    = er[1];
        cid  = s;
        cop  = req_rw[s*2 +: 2];
        c_da = req_da[s*4 +: 4];
        c_aa = req_aa[s*4 +: 4];
        c_ba = req_ba[s*4 +: 4];
        c_d  = req_d[s*16 +: 16];
        ea   = cop[1] ? regs[c_aa] : 16'h0;
        eb   = cop[1] ? regs[c_ba] : 16'h0;
        if (cop[0]) regs[c_da] = c_d;
        exp_q.push_back({ea, eb});
        last_id = s;
        busy    = 1;
        cyc     = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int id, input logic [1:0] rw, input logic [3:0] da,
                         input logic [3:0] aa, input logic [3:0] ba, input logic [15:0] d);
    req_rw[id*2 +: 2]  = rw;
    req_da[id*4 +: 4]  = da;
    req_aa[id*4 +: 4]  = aa;
    req_ba[id*4 +: 4]  = ba;
    req_d[id*16 +: 16] = d;
  endtask

  task automatic rand_req(input int id);
    set_req(id, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 16'($urandom));
  endtask

  // Called at posedge+1; returns at posedge+1 after the response handshake.
  task automatic do_cmd(input int id, input logic [1:0] rw, input logic [3:0] da,
                        input logic [3:0] aa, input logic [3:0] ba, input logic [15:0] d,
                        output logic [15:0] a, output logic [15:0] b, output int lat);
    int n;
    set_req(id, rw, da, aa, ba, d);
    req_valid[id] = 1'b1;
    rsp_ready[id] = 1'b1;
    n = 0;
    do begin @(negedge clk_main); n++; end while (!req_ready[id] && n < 50);
    chk("accept", req_ready[id], 1'b1);
    @(posedge clk_main); #1;
    req_valid[id] = 1'b0;
    lat = 0;
    do begin @(negedge clk_main); lat++; end while (!rsp_valid[id] && lat < 20);
    a = rsp_a;
    b = rsp_b;
    @(posedge clk_main); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] a, b;
    logic [1:0]  acc;
    int          lat, n, g, en_cnt;

    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    req_rw    = '0;
    req_da    = '0;
    req_aa    = '0;
    req_ba    = '0;
    req_d     = '0;
    repeat (3) @(posedge clk_main);
    #1 rst_n = 1'b1;
    @(posedge clk_main); #1;

    // Write then read back.
    do_cmd(0, RW_WR, 4'd3, 4'd0, 4'd0, 16'hBEEF, a, b, lat);
    chk("wr_latency", lat, 2);
    chk("wr_rsp_a", a, 16'h0);
    do_cmd(0, RW_RD, 4'd0, 4'd3, 4'd0, 16'h0, a, b, lat);
    chk("rd_latency", lat, 3);
    chk("rd_rsp_a", a, 16'hBEEF);
    chk("rd_rsp_b", b, 16'h0);

    // Read-modify-write of the same register returns the old value.
    do_cmd(0, RW_WR, 4'd5, 4'd0, 4'd0, 16'h0011, a, b, lat);
    do_cmd(1, RW_RDWR, 4'd5, 4'd5, 4'd3, 16'h2222, a, b, lat);
    chk("rdwr_old_a", a, 16'h0011);
    chk("rdwr_b", b, 16'hBEEF);
    do_cmd(0, RW_RD, 4'd0, 4'd5, 4'd5, 16'h0, a, b, lat);
    chk("rdwr_new_a", a, 16'h2222);

    // NOP from requester 1.
    do_cmd(1, RW_NOP, 4'd9, 4'd9, 4'd9, 16'h5555, a, b, lat);
    chk("nop_latency", lat, 2);
    chk("nop_rsp_ab", {a, b}, 32'h0);

    // Backpressure on requester 0 while requester 1 waits.
    set_req(0, RW_RD, 4'd0, 4'd3, 4'd5, 16'h0);
    set_req(1, RW_WR, 4'd7, 4'd0, 4'd0, 16'h7777);
    req_valid = 2'b01;
    rsp_ready = 2'b00;
    n = 0;
    do begin @(negedge clk_main); n++; end while (!req_ready[0] && n < 20);
    @(posedge clk_main); #1;
    req_valid = 2'b10;
    n = 0;
    do begin @(negedge clk_main); n++; end while (!rsp_valid[0] && n < 20);
    for (int i = 0; i < 10; i++) begin
      chk("bp_rsp_valid", rsp_valid, 2'b01);
      chk("bp_rsp_ab", {rsp_a, rsp_b}, {16'hBEEF, 16'h2222});
      chk("bp_req_ready", req_ready, 2'b00);
      @(negedge clk_main);
    end
    @(posedge clk_main); #1;
    rsp_ready[0] = 1'b1;
    do_cmd(1, RW_WR, 4'd7, 4'd0, 4'd0, 16'h7777, a, b, lat);

    // Reset in the middle of a pending response.
    set_req(1, RW_RD, 4'd0, 4'd7, 4'd3, 16'h0);
    req_valid = 2'b10;
    rsp_ready = 2'b00;
    n = 0;
    do begin @(negedge clk_main); n++; end while (!req_ready[1] && n < 20);
    @(posedge clk_main); #1;
    req_valid = 2'b00;
    n = 0;
    do begin @(negedge clk_main); n++; end while (!rsp_valid[1] && n < 20);
    chk("pre_rst_rsp_a", rsp_a, 16'h7777);
    @(posedge clk_main); #2;
    rst_n = 1'b0;
    @(negedge clk_main);
    chk("midrst_state", dbg_state, ST_IDLE);
    @(posedge clk_main); #1;
    rst_n     = 1'b1;
    rsp_ready = 2'b11;

    // Contention after reset: grants alternate starting with requester 0.
    rand_req(0);
    rand_req(1);
    req_rw    = 4'b0101;
    req_valid = 2'b11;
    g      = 0;
    en_cnt = 0;
    for (int c = 0; c < 60 && g < 4; c++) begin
      @(negedge clk_main);
      if (rf_en) en_cnt++;
      acc = req_ready & req_valid;
      if (acc != 2'b00) begin
        chk("grant_seq", acc, (g % 2 == 1) ? 2'b10 : 2'b01);
        g++;
      end
      @(posedge clk_main); #1;
      for (int i = 0; i < 2; i++) if (acc[i]) begin rand_req(i); req_rw[i*2 +: 2] = RW_WR; end
    end
    req_valid = 2'b00;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_main);
      if (rf_en) en_cnt++;
    end
    chk("contention_grants", g, 4);
    chk("contention_en_count", en_cnt, 4);
    @(posedge clk_main); #1;

    // Randomized traffic with withdrawals and random response backpressure.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk_main);
      acc = req_ready & req_valid;
      @(posedge clk_main); #1;
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) req_valid[i] = 1'b0;
        else if (req_valid[i] && $urandom_range(0, 19) == 0) req_valid[i] = 1'b0;
        else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          rand_req(i);
          req_valid[i] = 1'b1;
        end
      end
      rsp_ready = 2'($urandom_range(0, 3));
    end
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    repeat (10) @(posedge clk_main);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
